// File: rtl/seq_bit_gen.sv
// seq_bit_gen - serial bit-pattern transmitter.
//
// Sends a captured pattern MSB-first (bit len-1 first), one bit per clock,
// repeats it reps+1 times with GAP_CYCLES idle cycles between repetitions,
// and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk      in   clock, rising edge
//   n_reset  in   synchronous active-low reset
//   start    in   request a transmission (sampled only while idle)
//   abort    in   cancel a transmission in progress
//   pattern  in   [MAX_LEN-1:0] bits to send
//   len      in   [LEN_W-1:0]   bits per repetition, 1..MAX_LEN (larger clamps)
//   reps     in   [REP_W-1:0]   extra repetitions
//   d_out    out  serial data
//   d_valid  out  d_out carries a pattern bit
//   busy     out  transmission in progress
//   done     out  one-cycle pulse after the final bit
//   err      out  one-cycle pulse for a start with len==0
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; captures pattern/len/reps on accept
// SEND   | shifting out one pattern bit per cycle
// GAP    | idle spacing between repetitions, busy held high
// DONE   | last bit has gone out; raises done, then back to IDLE

module seq_bit_gen #(
   parameter int MAX_LEN    = 16,
   parameter int LEN_W      = 5,
   parameter int REP_W      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [REP_W-1:0]   reps,
   output logic               d_out,
   output logic               d_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [1:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [REP_W-1:0]   reps_q, reps_d;
   logic [LEN_W-1:0]   bit_idx_q, bit_idx_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               d_out_q, d_out_d;
   logic               d_valid_q, d_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [LEN_W-1:0]   len_clamp;
   logic [LEN_W-1:0]   shamt;
   logic               last_bit;

   assign len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   // Left-align the pattern so the first bit to send always sits in the MSB.
   assign shamt     = LEN_W'(MAX_LEN) - len_clamp;
   assign last_bit  = (bit_idx_q == len_q - 1'b1);

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      shreg_d   = shreg_q;
      len_d     = len_q;
      reps_d    = reps_q;
      bit_idx_d = bit_idx_q;
      rep_cnt_d = rep_cnt_q;
      gap_cnt_d = gap_cnt_q;
      d_out_d   = 1'b0;
      d_valid_d = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               if (len == '0) begin
                  err_d = 1'b1;
               end else begin
                  pat_d     = pattern << shamt;
                  shreg_d   = pattern << shamt;
                  len_d     = len_clamp;
                  reps_d    = reps;
                  bit_idx_d = '0;
                  rep_cnt_d = '0;
                  state_d   = S_SEND;
                  busy_d    = 1'b1;
               end
            end
         end

         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               d_out_d   = shreg_q[MAX_LEN-1];
               d_valid_d = 1'b1;
               shreg_d   = shreg_q << 1;
               bit_idx_d = bit_idx_q + 1'b1;
               if (last_bit) begin
                  // rep_cnt is compared before it increments, so reps at
                  // its maximum still yields 2^REP_W sends without wrapping.
                  if (rep_cnt_q == reps_q) begin
                     state_d = S_DONE;
                  end else if (GAP_CYCLES > 0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                  end else begin
                     bit_idx_d = '0;
                     rep_cnt_d = rep_cnt_q + 1'b1;
                     shreg_d   = pat_q;
                  end
               end
            end
         end

         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (gap_cnt_q == '0) begin
               state_d   = S_SEND;
               bit_idx_d = '0;
               rep_cnt_d = rep_cnt_q + 1'b1;
               shreg_d   = pat_q;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end

         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q   <= S_IDLE;
         pat_q     <= '0;
         shreg_q   <= '0;
         len_q     <= '0;
         reps_q    <= '0;
         bit_idx_q <= '0;
         rep_cnt_q <= '0;
         gap_cnt_q <= '0;
         d_out_q   <= 1'b0;
         d_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         shreg_q   <= shreg_d;
         len_q     <= len_d;
         reps_q    <= reps_d;
         bit_idx_q <= bit_idx_d;
         rep_cnt_q <= rep_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule
